// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier: FSM state encoding
// and the iteration-counter width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Start/done handshake and operand/product bus of the shift-and-add multiplier.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (output start, output a, output b, input busy, input done, input p);
  modport slave  (input start, input a, input b, output busy, output done, output p);
endinterface

// File: rtl/seq_shift_add_mult_step.sv
// One multiplier iteration: conditional add of mcand into the upper half of the
// accumulator, then a right shift of {carry, acc}.
module shift_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
    if (acc_in[0]) begin
      sum = sum + {1'b0, mcand};
    end
    // The carry lands in the MSB; the consumed multiplier bit falls off the LSB.
    acc_out = {sum, acc_in[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// WIDTH x WIDTH sequential shift-and-add multiplier, one product per WIDTH+1
// cycles. Define SIGNED_MULT_EN for two's-complement operands and product.
//
// state | meaning
// IDLE  | waiting for start, p holds last product
// RUN   | one shift-add iteration per cycle, busy high
// DONE  | done pulse cycle; start here re-launches immediately
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_shift_add_mult_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 done_q, done_d;

  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     load_a;
  logic [WIDTH-1:0]     load_b;
  logic [2*WIDTH-1:0]   final_p;
  logic                 last_iter;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_q),
    .mcand   (mcand_q),
    .acc_out (acc_step)
  );

`ifdef SIGNED_MULT_EN
  logic sign_neg_q, sign_neg_d;

  // Magnitudes are W-bit unsigned, so -2^(W-1) maps to 2^(W-1) without overflow.
  assign load_a  = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign load_b  = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  assign final_p = sign_neg_q ? (~acc_step + 1'b1) : acc_step;

  always_comb begin
    sign_neg_d = sign_neg_q;
    if ((state_q != RUN) && bus.start) begin
      sign_neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_neg_q <= 1'b0;
    end else begin
      sign_neg_q <= sign_neg_d;
    end
  end
`else
  assign load_a  = bus.a;
  assign load_b  = bus.b;
  assign final_p = acc_step;
`endif

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          mcand_d = load_a;
          acc_d   = {{WIDTH{1'b0}}, load_b};
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = DONE;
          p_d     = final_p;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and random checks of seq_shift_add_mult at WIDTH=4 and WIDTH=8
// against an arithmetic reference product.
module tb_seq_shift_add_mult;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [15:0] prev4;
  logic [15:0] prev8;

  seq_shift_add_mult_if #(.WIDTH(4)) s4 ();
  seq_shift_add_mult_if #(.WIDTH(8)) s8 ();

  seq_shift_add_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(s4));
  seq_shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(s8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer product of the operand values, reduced to 2*w bits.
  function automatic logic [15:0] ref_mult(input int w, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, r;
    sa = int'(a);
    sb = int'(b);
`ifdef SIGNED_MULT_EN
    if (a[w-1]) sa = sa - (1 << w);
    if (b[w-1]) sb = sb - (1 << w);
`endif
    r = sa * sb;
    r = r & ((1 << (2 * w)) - 1);
    return 16'(r);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Single start pulse on the 4-bit unit; start toggles randomly during RUN
  // and operands are scrambled after acceptance.
  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    logic [15:0] e;
    e = ref_mult(4, {4'b0, a}, {4'b0, b});
    @(negedge clk);
    s4.start = 1'b1; s4.a = a; s4.b = b;
    @(posedge clk); #1;
    chk("w4 busy at T", {15'b0, s4.busy}, 16'd1);
    chk("w4 p held at T", {8'b0, s4.p}, prev4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      s4.start = (k < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      s4.a = 4'($urandom); s4.b = 4'($urandom);
      @(posedge clk); #1;
      if (k < 4) begin
        chk("w4 busy in run", {15'b0, s4.busy}, 16'd1);
        chk("w4 no early done", {15'b0, s4.done}, 16'd0);
        chk("w4 p held in run", {8'b0, s4.p}, prev4);
      end else begin
        chk("w4 done at T+4", {15'b0, s4.done}, 16'd1);
        chk("w4 busy fall", {15'b0, s4.busy}, 16'd0);
        chk("w4 product", {8'b0, s4.p}, e);
      end
    end
    @(posedge clk); #1;
    chk("w4 done single", {15'b0, s4.done}, 16'd0);
    chk("w4 p held after", {8'b0, s4.p}, e);
    prev4 = e;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] e;
    e = ref_mult(8, a, b);
    @(negedge clk);
    s8.start = 1'b1; s8.a = a; s8.b = b;
    @(posedge clk); #1;
    chk("w8 busy at T", {15'b0, s8.busy}, 16'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      s8.start = 1'b0; s8.a = 8'($urandom); s8.b = 8'($urandom);
      @(posedge clk); #1;
      if (k < 8) begin
        chk("w8 no early done", {15'b0, s8.done}, 16'd0);
        chk("w8 p held in run", s8.p, prev8);
      end else begin
        chk("w8 done at T+8", {15'b0, s8.done}, 16'd1);
        chk("w8 product", s8.p, e);
      end
    end
    prev8 = e;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    prev4 = '0;
    prev8 = '0;
    rst_n = 1'b0;
    s4.start = 1'b0; s4.a = '0; s4.b = '0;
    s8.start = 1'b0; s8.a = '0; s8.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {15'b0, s4.busy}, 16'd0);
    chk("reset done", {15'b0, s4.done}, 16'd0);
    chk("reset p", {8'b0, s4.p}, 16'd0);
    chk("reset p w8", s8.p, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op4(4'd15, 4'd15);
    op4(4'd0, 4'd9);
    op4(4'd9, 4'd0);

    // start held high: done every WIDTH+1 cycles with no extra pulses
    @(negedge clk);
    s4.start = 1'b1; s4.a = 4'd3; s4.b = 4'd5;
    for (int k = 0; k < 15; k++) begin
      logic exp_done;
      @(posedge clk); #1;
      exp_done = ((k % 5) == 4);
      chk("held done", {15'b0, s4.done}, {15'b0, exp_done});
      chk("held busy", {15'b0, s4.busy}, {15'b0, !exp_done});
      chk("held p", {8'b0, s4.p}, (k >= 4) ? ref_mult(4, 8'd3, 8'd5) : prev4);
    end
    @(negedge clk);
    s4.start = 1'b0;
    prev4 = ref_mult(4, 8'd3, 8'd5);
    repeat (2) @(posedge clk);

    // reset mid-run discards the operation
    @(negedge clk);
    s4.start = 1'b1; s4.a = 4'd7; s4.b = 4'd6;
    @(posedge clk);
    @(negedge clk);
    s4.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst busy", {15'b0, s4.busy}, 16'd0);
    chk("rst done", {15'b0, s4.done}, 16'd0);
    chk("rst p", {8'b0, s4.p}, 16'd0);
    chk("rst p w8", s8.p, 16'd0);
    prev4 = '0;
    prev8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("no done after rst", {15'b0, s4.done}, 16'd0);
    end
    op4(4'd7, 4'd6);

    // signed-mode corner operands; in unsigned builds these are plain products
    op4(4'b1000, 4'b1000);
    op4(4'b1101, 4'd5);
    op4(4'd7, 4'b1111);
    op4(4'b1000, 4'd1);

    for (int i = 0; i < 10; i++) begin
      op4(4'($urandom), 4'($urandom));
    end

    op8(8'hFF, 8'hFF);
    op8(8'h80, 8'h80);
    op8(8'h00, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      op8(8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
# seq_shift_add_mult

Parametrised sequential shift-and-add multiplier with a start/done handshake. It replaces the fixed 4x4 combinational multiplier and computes a WIDTH x WIDTH product in WIDTH iterations. Operands are registered at start, and the product is held until the next start. It sits in the arithmetic datapath where multiplier area matters more than single-cycle latency.

## Interface
- WIDTH, 8: operand width in bits; legal range is WIDTH >= 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  multiplicand; sampled on the accepted start edge only.
- b  in  WIDTH  multiplier; sampled on the accepted start edge only.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse when p becomes valid.
- p  out  2*WIDTH  product; held stable from the done pulse until the next accepted start.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE after WIDTH iterations.
  - DONE -> RUN on start.
  - DONE -> IDLE otherwise.
- Accepted start loads the registers:
  - mcand = a.
  - acc = {WIDTH'b0, b}.
  - iteration counter = 0.
- Each RUN cycle:
  - If acc[0] = 1, the upper half gets acc[2W-1:W] + mcand; the carry out is kept as a (W+1)-bit sum.
  - The {carry, acc} value is then shifted right by 1 and the counter increments.
- After iteration WIDTH-1: p = acc, done = 1, and the state goes to DONE.
- Arithmetic is exact. p = a*b with no truncation, because 2*WIDTH bits always suffice.
- There is no early termination. Zero or small operands still take WIDTH RUN cycles.
- start in RUN is ignored; it is not queued and not flagged.
- a and b may change freely after the accepted start edge without affecting the result.
- Reset in any state:
  - Returns to IDLE asynchronously.
  - The in-flight result is discarded.
  - No done pulse is produced for the discarded operation.
- Reset values:
  - busy = 0, done = 0, p = 0.
  - Internal acc, mcand and counter = 0.

## Timing
- Edge T samples start=1 in IDLE or DONE; busy is high from T.
- Edges T+1 .. T+WIDTH each perform one iteration.
- At edge T+WIDTH:
  - p is updated.
  - done rises for exactly one cycle.
  - busy falls.
- Latency is WIDTH cycles from the accepted start edge to done.
- Back-to-back operation: start held high through the DONE cycle gives a new RUN immediately, so throughput is one product per WIDTH+1 cycles.
- p keeps its previous value during RUN and changes only at the done edge.

## Configuration
- SIGNED_MULT_EN defined:
  - a, b and p are two's complement.
  - At start, the magnitudes |a| and |b| are loaded and sign_neg = a[W-1]^b[W-1] is recorded.
  - At done, p = sign_neg ? -acc : acc.
  - The most negative operand is handled as a W-bit unsigned magnitude, so -2^(W-1) squared is exact.
  - Latency is unchanged.
- SIGNED_MULT_EN undefined: the block is unsigned only, and no sign logic is synthesised.

## Structure
- Package mult_pkg holds:
  - The state enum (IDLE, RUN, DONE).
  - A counter-width function, clog2(WIDTH+1).
- One sub-module, shift_add_step: a combinational (W+1)-bit conditional add plus right shift of the accumulator. It is instantiated once in the top.

## Test plan
- WIDTH=4, a=15, b=15, one-cycle start:
  - busy is high for 4 cycles.
  - done pulses at edge T+4.
  - p = 8'hE1 (225) and is held after done.
- WIDTH=4, a=0, b=9, then a=9, b=0:
  - p = 0 both times.
  - Latency is still 4 cycles.
- WIDTH=4, a=3, b=5 with start held high continuously:
  - Products complete every 5 cycles, p = 15 each time.
  - start pulses during RUN are ignored, with no extra done pulse.
- WIDTH=4, a=7, b=6, rst_n low at edge T+2:
  - busy = 0, done = 0, p = 0 immediately.
  - No done pulse follows.
  - A new start after release gives p = 42.
- WIDTH=8, a=8'hFF, b=8'hFF: p = 16'hFE01 at edge T+8.
- SIGNED_MULT_EN, WIDTH=4:
  - a=-8, b=-8 -> p = 8'h40.
  - a=-3, b=5 -> p = 8'hF1.
  - a=7, b=-1 -> p = 8'hF9.
